// File: rtl/alu_driver_if.sv
// rtl/alu_driver_if.sv - byte-stream command/response and ALU-side signal bundle for alu_driver
interface alu_driver_if #(
    parameter int N = 32
);
    logic [7:0]          rx_data;
    logic                rx_valid;
    logic                rx_ready;
    logic [7:0]          tx_data;
    logic                tx_valid;
    logic                tx_ready;
    logic [5:0]          alu_op_code;
    logic signed [N-1:0] alu_operand1;
    logic signed [N-1:0] alu_operand2;
    logic signed [N-1:0] alu_result;
    logic                alu_zero;
    logic                alu_overflow;

    modport master (
        input  rx_data, rx_valid,
        output rx_ready,
        output tx_data, tx_valid,
        input  tx_ready,
        output alu_op_code, alu_operand1, alu_operand2,
        input  alu_result, alu_zero, alu_overflow
    );

    modport slave (
        output rx_data, rx_valid,
        input  rx_ready,
        input  tx_data, tx_valid,
        output tx_ready,
        input  alu_op_code, alu_operand1, alu_operand2,
        output alu_result, alu_zero, alu_overflow
    );
endinterface

// File: rtl/alu_driver.sv
// rtl/alu_driver.sv - assembles byte-stream ALU commands, runs one ALU operation, streams back result and flags
module alu_driver #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    alu_driver_if.master bus,
    output logic         busy
);
    localparam int         NB   = N / 8;
    localparam logic [1:0] LAST = 2'(NB - 1);

    typedef enum logic [2:0] {
        RX_OP1,
        RX_OP2,
        RX_OPC,
        EXEC,
        TX_RES,
        TX_FLG
    } state_t;

    state_t       state_q, state_d;
    logic [1:0]   cnt_q, cnt_d;
    logic [N-1:0] op1_q, op1_d;
    logic [N-1:0] op2_q, op2_d;
    logic [N-1:0] a1_q, a1_d;
    logic [N-1:0] a2_q, a2_d;
    logic [5:0]   opc_q, opc_d;
    logic [N-1:0] res_q, res_d;
    logic         zero_q, zero_d;
    logic         ovf_q, ovf_d;
    logic         ill_q, ill_d;
    logic         rx_ready_q, rx_ready_d;
    logic         rx_fire, tx_fire, last_byte, legal;

    function automatic logic [N-1:0] put_byte(input logic [N-1:0] v, input logic [1:0] idx,
                                              input logic [7:0] b);
        logic [N-1:0] r;
        r = v;
        for (int i = 0; i < NB; i++) begin
            if (idx == 2'(i)) r[i*8 +: 8] = b;
        end
        return r;
    endfunction

    function automatic logic [7:0] get_byte(input logic [N-1:0] v, input logic [1:0] idx);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < NB; i++) begin
            if (idx == 2'(i)) r = v[i*8 +: 8];
        end
        return r;
    endfunction

    assign rx_fire   = bus.rx_valid & rx_ready_q;
    assign tx_fire   = bus.tx_valid & bus.tx_ready;
    assign last_byte = (cnt_q == LAST);
    assign legal     = (opc_q >= 6'h01 && opc_q <= 6'h03) || (opc_q >= 6'h20 && opc_q <= 6'h26);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        a1_d    = a1_q;
        a2_d    = a2_q;
        opc_d   = opc_q;
        res_d   = res_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        ill_d   = ill_q;

        // clear outranks any handshake happening on the same cycle
        if (clear) begin
            state_d = RX_OP1;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                RX_OP1: if (rx_fire) begin
                    op1_d = put_byte(op1_q, cnt_q, bus.rx_data);
                    if (last_byte) begin
                        cnt_d   = '0;
                        state_d = RX_OP2;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
                RX_OP2: if (rx_fire) begin
                    op2_d = put_byte(op2_q, cnt_q, bus.rx_data);
                    if (last_byte) begin
                        cnt_d   = '0;
                        state_d = RX_OPC;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
                RX_OPC: if (rx_fire) begin
                    a1_d    = op1_q;
                    a2_d    = op2_q;
                    opc_d   = bus.rx_data[5:0];
                    state_d = EXEC;
                end
                EXEC: begin
                    if (legal) begin
                        res_d  = bus.alu_result;
                        zero_d = bus.alu_zero;
                        ovf_d  = bus.alu_overflow;
                        ill_d  = 1'b0;
                    end else begin
                        res_d  = '0;
                        zero_d = 1'b0;
                        ovf_d  = 1'b0;
                        ill_d  = 1'b1;
                    end
                    cnt_d   = '0;
                    state_d = TX_RES;
                end
                TX_RES: if (tx_fire) begin
                    if (last_byte) begin
                        cnt_d   = '0;
                        state_d = TX_FLG;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
                TX_FLG: if (tx_fire) state_d = RX_OP1;
                default: begin
                    state_d = RX_OP1;
                    cnt_d   = '0;
                end
            endcase
        end

        rx_ready_d = (state_d == RX_OP1) || (state_d == RX_OP2) || (state_d == RX_OPC);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RX_OP1;
            cnt_q      <= '0;
            op1_q      <= '0;
            op2_q      <= '0;
            a1_q       <= '0;
            a2_q       <= '0;
            opc_q      <= '0;
            res_q      <= '0;
            zero_q     <= 1'b0;
            ovf_q      <= 1'b0;
            ill_q      <= 1'b0;
            rx_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op1_q      <= op1_d;
            op2_q      <= op2_d;
            a1_q       <= a1_d;
            a2_q       <= a2_d;
            opc_q      <= opc_d;
            res_q      <= res_d;
            zero_q     <= zero_d;
            ovf_q      <= ovf_d;
            ill_q      <= ill_d;
            rx_ready_q <= rx_ready_d;
        end
    end

    // tx_data is a pure function of held state, so it cannot move while the sink stalls
    always_comb begin
        bus.tx_valid = 1'b0;
        bus.tx_data  = '0;
        if (state_q == TX_RES) begin
            bus.tx_valid = 1'b1;
            bus.tx_data  = get_byte(res_q, cnt_q);
        end else if (state_q == TX_FLG) begin
            bus.tx_valid = 1'b1;
            bus.tx_data  = {5'b0, ill_q, ovf_q, zero_q};
        end
    end

    assign bus.rx_ready     = rx_ready_q;
    assign bus.alu_op_code  = opc_q;
    assign bus.alu_operand1 = a1_q;
    assign bus.alu_operand2 = a2_q;
    assign busy             = !(state_q == RX_OP1 && cnt_q == 2'd0);
endmodule

// File: tb/tb_alu_driver.sv
// tb/tb_alu_driver.sv - self-checking bench for alu_driver with a frame-level response model
module tb_alu_driver;
    localparam int N  = 32;
    localparam int NB = N / 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic clear = 1'b0;
    logic busy;

    alu_driver_if #(.N(N)) bus ();

    alu_driver #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ALU stand-in: returns {overflow, zero, result}
    function automatic logic [N+1:0] alu_fn(input logic [5:0] op, input logic [N-1:0] a,
                                           input logic [N-1:0] b);
        logic [N-1:0] r;
        logic         o;
        o = 1'b0;
        case (op)
            6'h20: begin
                r = a + b;
                o = (a[N-1] == b[N-1]) && (r[N-1] != a[N-1]);
            end
            6'h21: begin
                r = a - b;
                o = (a[N-1] != b[N-1]) && (r[N-1] != a[N-1]);
            end
            6'h22:   r = a & b;
            6'h23:   r = a | b;
            default: r = a ^ b;
        endcase
        return {o, (r == '0), r};
    endfunction

    logic [N+1:0] alu_out;
    assign alu_out          = alu_fn(bus.alu_op_code, bus.alu_operand1, bus.alu_operand2);
    assign bus.alu_result   = alu_out[N-1:0];
    assign bus.alu_zero     = alu_out[N];
    assign bus.alu_overflow = alu_out[N+1];

    int cyc   = 0;
    int edges = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edges <= 0;
        else if (edges < 10) edges <= edges + 1;
    end

    logic [7:0]   part[$];
    logic [7:0]   expq[$];
    logic [7:0]   got[$];
    logic [5:0]   cur_opc;
    logic [N-1:0] cur_a, cur_b;
    logic [N+1:0] m_r;
    logic         m_legal;
    int           opc_cyc  = -100;
    int           last_lat = 0;
    logic         prev_txv, prev_stall, prev_clear;
    logic [7:0]   prev_data;

    always @(negedge clk) begin
        if (!rst_n) begin
            part.delete();
            expq.delete();
            prev_txv   = 1'b0;
            prev_stall = 1'b0;
            prev_clear = 1'b0;
        end else begin
            chk("rx_ready", bus.rx_ready, 64'(edges > 0 && expq.size() == 0));
            chk("busy", busy, 64'(part.size() != 0 || expq.size() != 0));
            if (prev_clear) chk("tx_valid_after_clear", bus.tx_valid, 0);
            if (expq.size() == 0) chk("tx_valid_idle", bus.tx_valid, 0);
            if (expq.size() > 0) begin
                chk("alu_op_code", bus.alu_op_code, cur_opc);
                chk("alu_operand1", bus.alu_operand1, cur_a);
                chk("alu_operand2", bus.alu_operand2, cur_b);
            end
            if (bus.tx_valid) begin
                if (!prev_txv) begin
                    last_lat = cyc - opc_cyc;
                    chk("latency", last_lat, 2);
                end
                if (prev_stall) chk("tx_stable", bus.tx_data, prev_data);
            end

            if (clear) begin
                part.delete();
                expq.delete();
            end else begin
                if (bus.rx_valid && bus.rx_ready) begin
                    part.push_back(bus.rx_data);
                    if (part.size() == 2 * NB + 1) begin
                        cur_a = '0;
                        cur_b = '0;
                        for (int i = 0; i < NB; i++) begin
                            cur_a[i*8 +: 8] = part[i];
                            cur_b[i*8 +: 8] = part[NB+i];
                        end
                        cur_opc = part[2*NB][5:0];
                        m_legal = (cur_opc >= 6'h01 && cur_opc <= 6'h03) ||
                                  (cur_opc >= 6'h20 && cur_opc <= 6'h26);
                        m_r = m_legal ? alu_fn(cur_opc, cur_a, cur_b) : '0;
                        for (int i = 0; i < NB; i++) expq.push_back(m_r[i*8 +: 8]);
                        expq.push_back({5'b0, !m_legal, m_r[N+1], m_r[N]});
                        opc_cyc = cyc;
                        part.delete();
                    end
                end
                if (bus.tx_valid && bus.tx_ready) begin
                    if (expq.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL tx_unexpected: got byte %0h expected none", bus.tx_data);
                    end else begin
                        chk("tx_byte", bus.tx_data, expq[0]);
                        void'(expq.pop_front());
                    end
                    got.push_back(bus.tx_data);
                end
            end
            prev_txv   = bus.tx_valid;
            prev_stall = bus.tx_valid && !bus.tx_ready && !clear;
            prev_data  = bus.tx_data;
            prev_clear = clear;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        while (!bus.rx_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            n_checks++;
            n_fail++;
            $display("FAIL rx_timeout: rx_ready low for %0d cycles, required high", t);
        end
        @(posedge clk);
        #1 bus.rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [N-1:0] a, input logic [N-1:0] b, input logic [7:0] op);
        for (int i = 0; i < NB; i++) send_byte(a[i*8 +: 8]);
        for (int i = 0; i < NB; i++) send_byte(b[i*8 +: 8]);
        send_byte(op);
    endtask

    task automatic drain(input int stall);
        int   t, w;
        logic hs;
        t = 0;
        w = 0;
        while (got.size() < NB + 1 && t < 300) begin
            bus.tx_ready = (bus.tx_valid && w >= stall);
            hs = bus.tx_valid && bus.tx_ready;
            if (bus.tx_valid) w++;
            @(posedge clk);
            #1;
            if (hs) w = 0;
            t++;
        end
        bus.tx_ready = 1'b0;
        if (t >= 300) begin
            n_checks++;
            n_fail++;
            $display("FAIL tx_timeout: got %0d bytes, required %0d", got.size(), NB + 1);
        end
    endtask

    task automatic expect_resp(input string name, input logic [39:0] exp);
        chk({name, "_count"}, got.size(), NB + 1);
        for (int i = 0; i < NB + 1; i++) begin
            if (i < got.size()) chk(name, got[i], exp[39-8*i -: 8]);
        end
    endtask

    initial begin
        int t;
        bus.rx_valid = 1'b0;
        bus.rx_data  = '0;
        bus.tx_ready = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_rx_ready", bus.rx_ready, 0);
        chk("rst_tx_valid", bus.tx_valid, 0);
        chk("rst_tx_data", bus.tx_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_op_code", bus.alu_op_code, 0);
        chk("rst_operand1", bus.alu_operand1, 0);
        chk("rst_operand2", bus.alu_operand2, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rx_ready_before_edge", bus.rx_ready, 0);
        @(posedge clk);
        #1 chk("rx_ready_first_edge", bus.rx_ready, 1);

        got.delete();
        send_frame(32'd5, 32'd3, 8'h20);
        drain(0);
        expect_resp("add_5_3", 40'h08_00_00_00_00);
        chk("add_latency", last_lat, 2);

        got.delete();
        send_frame(32'h7FFF_FFFF, 32'd1, 8'h20);
        drain(3);
        expect_resp("add_ovf_stall", 40'h00_00_00_80_02);

        got.delete();
        send_frame(32'h1234_5678, 32'h0102_0304, 8'h20);
        drain(1);
        expect_resp("add_bytes", 40'h7C_59_36_13_00);

        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h01);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_rx_ready", bus.rx_ready, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        got.delete();
        send_frame(32'd1, 32'd1, 8'h20);
        drain(0);
        repeat (10) @(posedge clk);
        #1 expect_resp("after_reset", 40'h02_00_00_00_00);

        got.delete();
        send_frame(32'd5, 32'd3, 8'h20);
        bus.tx_ready = 1'b1;
        t = 0;
        while (got.size() < 1 && t < 50) begin
            @(posedge clk);
            #1 t++;
        end
        chk("clear_first_byte_seen", got.size(), 1);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear        = 1'b0;
        bus.tx_ready = 1'b0;
        chk("clear_tx_valid", bus.tx_valid, 0);
        chk("clear_busy", busy, 0);
        chk("clear_rx_ready", bus.rx_ready, 1);
        chk("clear_bytes", got.size(), 1);
        if (got.size() > 0) chk("clear_byte0", got[0], 8'h08);

        got.delete();
        send_frame(32'd3, 32'd3, 8'h21);
        drain(0);
        expect_resp("sub_zero", 40'h00_00_00_00_01);

        got.delete();
        send_frame(32'd5, 32'd9, 8'h3F);
        drain(2);
        expect_resp("illegal_3f", 40'h00_00_00_00_04);

        got.delete();
        send_frame(32'd2, 32'd3, 8'hE0);
        drain(0);
        expect_resp("opc_hi_bits", 40'h05_00_00_00_00);

        got.delete();
        send_frame(32'h0F, 32'h05, 8'h26);
        drain(0);
        expect_resp("legal_26", 40'h0A_00_00_00_00);

        got.delete();
        send_frame(32'h0F, 32'h05, 8'h27);
        drain(0);
        expect_resp("illegal_27", 40'h00_00_00_00_04);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_driver.md
ALU_DRIVER -- requirements
Module: alu_driver

Interface
REQ-001 SHALL have parameter N, default 32, meaning operand/result width in bits; legal values 8, 16, 24, 32.
REQ-002 SHALL have port clk  input  1  single system clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port clear  input  1  synchronous abort; returns block to RX_OP1.
REQ-005 SHALL have port rx_data  input  8  inbound command byte.
REQ-006 SHALL have port rx_valid  input  1  rx_data valid.
REQ-007 SHALL have port rx_ready  output  1  block accepts rx_data this cycle.
REQ-008 SHALL have port tx_data  output  8  outbound response byte.
REQ-009 SHALL have port tx_valid  output  1  tx_data valid.
REQ-010 SHALL have port tx_ready  input  1  sink accepts tx_data this cycle.
REQ-011 SHALL have port alu_op_code  output  6  op code driven to ALU.
REQ-012 SHALL have ports alu_operand1, alu_operand2  output  N  signed operands driven to ALU.
REQ-013 SHALL have port alu_result  input  N  signed ALU result.
REQ-014 SHALL have ports alu_zero, alu_overflow  input  1  ALU flags.
REQ-015 SHALL have port busy  output  1  high in any state other than RX_OP1 with zero bytes received.

Function
REQ-016 SHALL implement states RX_OP1, RX_OP2, RX_OPC, EXEC, TX_RES, TX_FLG.
REQ-017 SHALL accept a byte only on a cycle with rx_valid & rx_ready; rx_ready high only in RX_OP1, RX_OP2, RX_OPC.
REQ-018 SHALL assemble operand1 from N/8 bytes, little-endian (first byte -> bits [7:0]), then operand2 likewise, then one op-code byte.
REQ-019 SHALL use op-code byte bits [5:0] and ignore bits [7:6].
REQ-020 SHALL hold a byte counter that wraps to 0 at each operand boundary; RX_OP1->RX_OP2 and RX_OP2->RX_OPC on acceptance of the last byte of the field.
REQ-021 SHALL go RX_OPC->EXEC on op-code acceptance, with alu_operand1/2 and alu_op_code registered and stable from the following cycle until the next frame's first byte is accepted.
REQ-022 SHALL in EXEC (exactly one cycle) capture alu_result, alu_zero, alu_overflow and go to TX_RES.
REQ-023 SHALL treat legal op codes as 000001, 000010, 000011, 100000-100110; any other code SHALL set captured result to 0, zero/overflow to 0, and illegal flag to 1.
REQ-024 SHALL in TX_RES send captured result as N/8 bytes little-endian, then in TX_FLG send flags byte {5'b0, illegal, overflow, zero}.
REQ-025 SHALL advance a TX byte only on tx_valid & tx_ready; tx_data SHALL stay stable while tx_valid & !tx_ready.
REQ-026 SHALL return to RX_OP1 the cycle after the flags byte is accepted; latency from op-code acceptance to first tx_valid is 2 cycles.
REQ-027 SHALL give clear priority over every other event, including simultaneous byte handshakes; clear drops tx_valid next cycle and discards partial frames; alu_* outputs keep last values.

Reset
REQ-028 SHALL on rst_n low asynchronously force state RX_OP1, counters 0, rx_ready 0 while asserted, tx_valid 0, tx_data 0, alu_op_code 0, alu_operand1/2 0, captured result/flags 0, busy 0.
REQ-029 SHALL assert rx_ready on the first clock edge after rst_n deasserts; reset mid-frame discards the frame.

Verification
REQ-030 N=32, send 05 00 00 00, 03 00 00 00, 20; ALU model returns 8 -> tx bytes 08 00 00 00 00, first tx_valid 2 cycles after op-code accept.
REQ-031 Send op1=3, op2=3, opcode 21 (SUB); ALU returns 0, zero=1 -> tx 00 00 00 00 01.
REQ-032 Send opcode 3F -> tx 00 00 00 00 04 regardless of ALU inputs.
REQ-033 Hold tx_ready low 3 cycles during each TX byte -> tx_data/tx_valid stable, no byte lost or duplicated; rx_ready 0 throughout.
REQ-034 Pulse rst_n low after 5 of 9 command bytes, then send full ADD frame 01..,01..,20 -> exactly one response 02 00 00 00 00.
REQ-035 Assert clear together with second TX byte handshake -> tx_valid 0 next cycle, state RX_OP1, next full frame processed normally.
